// File: rtl/sequence_loader.sv
// Write-side front end of the sequence buffer: streams host query/database word pairs
// into consecutive buffer registers and pulses load_done once a full pair of sequences is stored.
module sequence_loader #(
  parameter int unsigned SEQ_LENGTH    = 32,
  parameter int unsigned LETTER_WIDTH  = 2,
  parameter int unsigned INPUT_WIDTH   = 8,
  parameter int unsigned NUM_BUFF_REGS = SEQ_LENGTH * LETTER_WIDTH / INPUT_WIDTH,
  parameter int unsigned BUFF_CNT_W    = $clog2(NUM_BUFF_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] query_in,
  input  logic [INPUT_WIDTH-1:0] database_in,
  output logic                   wr_en_buff,
  output logic [BUFF_CNT_W-1:0]  count,
  output logic [INPUT_WIDTH-1:0] query_seq_in,
  output logic [INPUT_WIDTH-1:0] database_seq_in,
  output logic                   busy,
  output logic                   load_done
);

  localparam logic [BUFF_CNT_W-1:0] LAST_IDX = BUFF_CNT_W'(NUM_BUFF_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BUFF_CNT_W-1:0]  idx_q, idx_d;
  logic                   wr_en_q, wr_en_d;
  logic [BUFF_CNT_W-1:0]  count_q, count_d;
  logic [INPUT_WIDTH-1:0] qry_q, qry_d;
  logic [INPUT_WIDTH-1:0] db_q, db_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept;

  // Ready is combinational so an abort blocks acceptance on the same edge.
  assign in_ready = (state_q == LOAD) && !abort;
  assign accept   = in_valid && in_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    count_d = count_q;
    qry_d   = qry_q;
    db_d    = db_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          qry_d   = query_in;
          db_d    = database_in;
          count_d = idx_q;
          wr_en_d = 1'b1;
          idx_d   = idx_q + BUFF_CNT_W'(1);
          if (idx_q == LAST_IDX) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      count_q <= '0;
      qry_q   <= '0;
      db_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      count_q <= count_d;
      qry_q   <= qry_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_en_buff      = wr_en_q;
  assign count           = count_q;
  assign query_seq_in    = qry_q;
  assign database_seq_in = db_q;
  assign busy            = busy_q;
  assign load_done       = done_q;

endmodule

// File: tb/tb_sequence_loader.sv
// Scoreboard bench for sequence_loader: stimulus queues expected writes and load_done edges,
// a monitor pops and compares them whenever the DUT strobes an output.
module tb_sequence_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, in_valid;
  logic       in_ready;
  logic [7:0] query_in, database_in;
  logic       wr_en_buff;
  logic [2:0] count;
  logic [7:0] query_seq_in, database_seq_in;
  logic       busy, load_done;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] cnt;
    logic [7:0] q;
    logic [7:0] d;
    int         edg;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  sequence_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .query_in        (query_in),
    .database_in     (database_in),
    .wr_en_buff      (wr_en_buff),
    .count           (count),
    .query_seq_in    (query_seq_in),
    .database_seq_in (database_seq_in),
    .busy            (busy),
    .load_done       (load_done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // Drive one accepted word at the current negedge and record what the buffer must see.
  task automatic send_word(input logic [7:0] q, input logic [7:0] d, input logic [2:0] c,
                           input bit last);
    wr_t e;
    in_valid    = 1'b1;
    query_in    = q;
    database_in = d;
    e.cnt = c; e.q = q; e.d = d; e.edg = cyc + 1;
    wq.push_back(e);
    if (last) dq.push_back(cyc + 2);
    @(negedge clk);
    in_valid    = 1'b0;
    query_in    = 8'hEE;
    database_in = 8'hEE;
    start       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a load and push n words; alt inserts a bubble before each word,
  // start_at re-pulses start alongside that word index.
  task automatic load(input logic [7:0] bq, input logic [7:0] bd, input bit alt,
                      input int n, input int start_at);
    do_start();
    for (int k = 0; k < n; k++) begin
      if (alt) @(negedge clk);
      start = (k == start_at);
      send_word(bq + 8'(k), bd + 8'(k), 3'(k), k == 7);
    end
  endtask

  // Walk through FLUSH/DONE, optionally pulsing start while in DONE.
  task automatic finish_load(input bit start_in_done);
    @(negedge clk);
    chk("done_pulse", 32'(load_done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    query_in = 8'h00; database_in = 8'h00;

    // Monitor: compare every strobe against the scoreboard.
    fork
      forever begin
        @(posedge clk);
        #1;
        if (wr_en_buff) begin
          chk("write_expected", 32'(wq.size() != 0), 32'd1);
          if (wq.size() != 0) begin
            wr_t e;
            e = wq.pop_front();
            chk("wr_edge", 32'(cyc), 32'(e.edg));
            chk("wr_count", 32'(count), 32'(e.cnt));
            chk("wr_query", 32'(query_seq_in), 32'(e.q));
            chk("wr_database", 32'(database_seq_in), 32'(e.d));
          end
        end
        if (load_done) begin
          chk("done_expected", 32'(dq.size() != 0), 32'd1);
          if (dq.size() != 0) chk("done_edge", 32'(cyc), 32'(dq.pop_front()));
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset_outputs", {23'd0, wr_en_buff, count, busy, load_done, in_ready, 1'b0},
        32'd0);
    chk("reset_data", {16'd0, query_seq_in, database_seq_in}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: back-to-back load.
    load(8'h10, 8'h80, 1'b0, 8, -1);
    finish_load(1'b0);

    // T2: bubble on alternate cycles.
    load(8'h20, 8'h90, 1'b1, 8, -1);
    finish_load(1'b0);

    // T3: start during LOAD and during DONE is ignored.
    load(8'h30, 8'hA0, 1'b0, 8, 3);
    finish_load(1'b1);
    repeat (3) @(negedge clk);
    chk("no_second_load", 32'(busy), 32'd0);

    // T4: abort after three accepts.
    load(8'h40, 8'hB0, 1'b0, 3, -1);
    chk("ready_in_load", 32'(in_ready), 32'd1);
    abort = 1'b1; in_valid = 1'b1; query_in = 8'hAA; database_in = 8'hAA;
    #1;
    chk("ready_on_abort", 32'(in_ready), 32'd0);
    chk("busy_before_abort", 32'(busy), 32'd1);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("idle_after_abort", {30'd0, busy, wr_en_buff}, 32'd0);
    repeat (3) @(negedge clk);
    load(8'h50, 8'hC0, 1'b0, 8, -1);
    finish_load(1'b0);

    // T5: asynchronous reset mid-load.
    load(8'h60, 8'hD0, 1'b0, 5, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, wr_en_buff, count, busy}, 32'd0);
    chk("async_rst_data", {15'd0, load_done, query_seq_in, database_seq_in}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(8'h70, 8'hE0, 1'b0, 8, -1);
    finish_load(1'b0);

    // T6: second load started the cycle after load_done.
    load(8'h01, 8'hF0, 1'b0, 8, -1);
    finish_load(1'b0);
    load(8'h41, 8'h0F, 1'b0, 8, -1);
    finish_load(1'b0);

    repeat (4) @(negedge clk);
    chk("writes_outstanding", 32'(wq.size()), 32'd0);
    chk("dones_outstanding", 32'(dq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
